// File: rtl/mantissa_mult_pkg.sv
// Shared types and constants for the 28x28 mantissa multiplier datapath.
// Holds the SIMD op encoding, widths, FSM states and the partial-product keep rule.
package mantissa_mult_pkg;

  localparam int SUB_W  = 7;
  localparam int N_SUB  = 4;
  localparam int PP_W   = 2 * SUB_W;
  localparam int PROD_W = 8 * SUB_W;

  typedef enum logic [1:0] {
    OP_4X7     = 2'b00,
    OP_2X14    = 2'b01,
    OP_1X28    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } state_t;

  // A partial product pp[i][j] contributes only when row i and column j belong to the same lane.
  function automatic logic pp_keep(input op_t op, input logic [1:0] i, input logic [1:0] j);
    case (op)
      OP_4X7:  pp_keep = (i == j);
      OP_2X14: pp_keep = (i[1] == j[1]);
      OP_1X28: pp_keep = 1'b1;
      default: pp_keep = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mantissa_row_gate.sv
// Gates one row of four 14-bit partial products by SIMD mode and returns
// the sum of the surviving terms, each aligned to its 7*(i+j) weight.
module mantissa_row_gate
  import mantissa_mult_pkg::*;
(
  input  logic [1:0]        row_idx,
  input  op_t               op,
  input  logic [PROD_W-1:0] row,
  output logic [PROD_W-1:0] sum
);

  // NOTE: combinational logic uses blocking '=' and assigns a default first, so no latch is inferred.
  always_comb begin
    sum = '0;
    for (int j = 0; j < N_SUB; j++) begin
      if (pp_keep(op, row_idx, 2'(j)))
        sum = sum + (PROD_W'(row[j*PP_W +: PP_W]) << (SUB_W * (int'(row_idx) + j)));
    end
  end

endmodule

// File: rtl/mantissa_pp_accumulator.sv
// Consumes four gated partial-product rows per product, accumulates them into
// a 56-bit result and holds it on a valid/ready output until accepted.
module mantissa_pp_accumulator
  import mantissa_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [PROD_W-1:0] in_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_op,
  output logic [PROD_W-1:0] out_prod,
  output logic              out_err
);

  state_t            state;
  logic [1:0]        row;
  op_t               op_q;
  op_t               row_op;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] gated;
  logic [PROD_W-1:0] acc_next;
  logic              beat;

  assign in_ready = (state != ST_DONE) || out_ready;
  assign beat     = in_valid && in_ready;

  // Row counter is 0 in IDLE and DONE, so a row-0 beat uses the live op, later rows the latched one.
  assign row_op   = (row == 2'd0) ? op_t'(in_op) : op_q;
  assign acc_next = (row == 2'd0) ? gated : acc + gated;

  mantissa_row_gate u_row_gate (
    .row_idx (row),
    .op      (row_op),
    .row     (in_row),
    .sum     (gated)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      row       <= 2'd0;
      op_q      <= OP_4X7;
      acc       <= '0;
      out_valid <= 1'b0;
      out_op    <= 2'b00;
      out_prod  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (beat) begin
            op_q  <= op_t'(in_op);
            acc   <= acc_next;
            row   <= 2'd1;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            acc <= acc_next;
            if (row == 2'd3) begin
              row       <= 2'd0;
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_op    <= op_q;
              out_err   <= (op_q == OP_ILLEGAL);
              out_prod  <= (op_q == OP_ILLEGAL) ? '0 : acc_next;
            end else begin
              row <= row + 2'd1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (beat) begin
              op_q  <= op_t'(in_op);
              acc   <= acc_next;
              row   <= 2'd1;
              state <= ST_ACCUM;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
